// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, FSM state encoding and helpers for the 8-way round-robin arbiter.
// Purely declarative; no logic of its own.
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot8(input logic [ID_W-1:0] id);
        logic [N_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Requesters strictly below ptr; these win over everything else next round.
    function automatic logic [N_REQ-1:0] below_mask(input logic [ID_W-1:0] ptr);
        return (N_REQ'(1) << ptr) - N_REQ'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesters (master side) and the arbiter (slave side).
// Combinational wiring only.
interface rr_arbiter8_if
    import rr_arbiter8_pkg::*;
#(
    parameter int HOLD_W = 3
);

    logic                en;
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    gnt;
    logic [ID_W-1:0]     gnt_id;
    logic                gnt_v;
    logic [HOLD_W-1:0]   hold_cnt;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_v,
        input  hold_cnt
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_v,
        output hold_cnt
    );

endinterface

// File: rtl/rr_arbiter8_pri_enc8.sv
// 8-bit priority encoder, MSB wins; combinational, zero latency.
// No backpressure: vld_o simply flags a non-zero input.
module arb_pri_enc8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             vld_o
);

    always_comb begin
        idx_o = '0;
        vld_o = |vec_i;
        for (int k = 0; k < N_REQ; k++) begin
            if (vec_i[k]) begin
                idx_o = ID_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter over 8 requesters with a bounded hold per ownership; grant one cycle after req.
// Owner keeps the grant while requesting, up to MAX_HOLD cycles; en low releases and blocks grants.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
)
(
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic               gnt_v_q, gnt_v_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [ID_W-1:0]    last_id_q, last_id_d;

    logic [ID_W-1:0]    ptr;
    logic [N_REQ-1:0]   masked_req;
    logic [ID_W-1:0]    masked_id, raw_id, winner;
    logic               masked_vld, raw_vld;
    logic               owner_req, timed_out, release_grant, can_grant;

    // In GRANT the pointer is the live owner; in IDLE it is the last one served.
    assign ptr        = (state_q == GRANT) ? gnt_id_q : last_id_q;
    assign masked_req = bus.req & below_mask(ptr);

    arb_pri_enc8 u_enc_masked (
        .vec_i (masked_req),
        .idx_o (masked_id),
        .vld_o (masked_vld)
    );

    arb_pri_enc8 u_enc_raw (
        .vec_i (bus.req),
        .idx_o (raw_id),
        .vld_o (raw_vld)
    );

    assign winner        = masked_vld ? masked_id : raw_id;
    assign can_grant     = bus.en && raw_vld;
    assign owner_req     = bus.req[gnt_id_q];
    assign timed_out     = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    assign release_grant = !bus.en || !owner_req || timed_out;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_v_d   = gnt_v_q;
        hold_d    = hold_q;
        last_id_d = last_id_q;

        unique case (state_q)
            IDLE: begin
                if (can_grant) begin
                    state_d   = GRANT;
                    gnt_d     = onehot8(winner);
                    gnt_id_d  = winner;
                    gnt_v_d   = 1'b1;
                    hold_d    = '0;
                    last_id_d = winner;
                end
            end
            GRANT: begin
                if (!release_grant) begin
                    // Only reachable past all-ones when MAX_HOLD is unlimited.
                    hold_d = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
                end else if (can_grant) begin
                    gnt_d     = onehot8(winner);
                    gnt_id_d  = winner;
                    gnt_v_d   = 1'b1;
                    hold_d    = '0;
                    last_id_d = winner;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    gnt_v_d = 1'b0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                gnt_v_d = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_v_q   <= 1'b0;
            hold_q    <= '0;
            last_id_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_v_q   <= gnt_v_d;
            hold_q    <= hold_d;
            last_id_q <= last_id_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.gnt_id   = gnt_id_q;
    assign bus.gnt_v    = gnt_v_q;
    assign bus.hold_cnt = hold_q;

    a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt_q));
    a_gnt_v_match: assert property (@(posedge clk) gnt_v_q == (|gnt_q));

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: scripted scenarios plus randomized traffic against a rotation-order model.
module tb_rr_arbiter8;

    localparam int MAXH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    rr_arbiter8_if #(.HOLD_W(3)) bus ();

    rr_arbiter8 #(.MAX_HOLD(MAXH), .HOLD_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: owner index (-1 = idle), cycles held, last served, last reported id.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_last  = 0;
    int m_gid   = 0;

    // Scan order after serving 'from' is from-1 ... 0, 7 ... from.
    function automatic int next_winner(input logic [7:0] r, input int from);
        for (int i = 1; i <= 8; i++) begin
            int c;
            c = (from - i + 8) % 8;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt();
        logic [7:0] g;
        g = 8'h00;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_step();
        int w;
        logic rel;
        if (rst) begin
            m_owner = -1; m_cnt = 0; m_last = 0; m_gid = 0;
        end else if (m_owner < 0) begin
            if (bus.en && bus.req != 8'h00) begin
                w = next_winner(bus.req, m_last);
                m_owner = w; m_cnt = 0; m_last = w; m_gid = w;
            end
        end else begin
            rel = !bus.en || !bus.req[m_owner] || (MAXH != 0 && m_cnt == MAXH - 1);
            if (!rel) begin
                m_cnt = (m_cnt == 7) ? 7 : m_cnt + 1;
            end else if (bus.en && bus.req != 8'h00) begin
                w = next_winner(bus.req, m_owner);
                m_owner = w; m_cnt = 0; m_last = w; m_gid = w;
            end else begin
                m_owner = -1; m_cnt = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.en  = 1'b1;
        bus.req = 8'h00;
        do_reset();
        checks++;
        if (bus.gnt !== 8'h00 || bus.gnt_v !== 1'b0 || bus.gnt_id !== 3'd0 || bus.hold_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset: gnt=%h v=%b id=%0d cnt=%0d, want 00/0/0/0",
                     bus.gnt, bus.gnt_v, bus.gnt_id, bus.hold_cnt);
        end
    endtask

    task automatic test_timeout_rotate();
        logic [7:0] want;
        do_reset();
        bus.req = 8'h81;
        for (int c = 0; c < 16; c++) begin
            tick();
            want = (((c / 4) % 2) == 0) ? 8'h80 : 8'h01;
            checks++;
            if (bus.gnt !== want || bus.hold_cnt !== 3'(c % 4) || bus.gnt_v !== 1'b1) begin
                errors++;
                $display("FAIL timeout_rotate c=%0d: gnt=%h cnt=%0d v=%b, want %h/%0d/1",
                         c, bus.gnt, bus.hold_cnt, bus.gnt_v, want, c % 4);
            end
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        bus.req = 8'h20;
        tick();
        tick();
        checks++;
        if (bus.gnt !== 8'h20 || bus.hold_cnt !== 3'd1) begin
            errors++;
            $display("FAIL owner_drop_hold: gnt=%h cnt=%0d, want 20/1", bus.gnt, bus.hold_cnt);
        end
        bus.req = 8'h0C;
        tick();
        checks++;
        if (bus.gnt !== 8'h08 || bus.gnt_id !== 3'd3 || bus.hold_cnt !== 3'd0 || bus.gnt_v !== 1'b1) begin
            errors++;
            $display("FAIL owner_drop_handoff: gnt=%h id=%0d cnt=%0d v=%b, want 08/3/0/1",
                     bus.gnt, bus.gnt_id, bus.hold_cnt, bus.gnt_v);
        end
    endtask

    task automatic test_single_timeout();
        do_reset();
        bus.req = 8'h04;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus.gnt !== 8'h04 || bus.gnt_v !== 1'b1 || bus.hold_cnt !== 3'(c % 4)) begin
                errors++;
                $display("FAIL single_timeout c=%0d: gnt=%h v=%b cnt=%0d, want 04/1/%0d",
                         c, bus.gnt, bus.gnt_v, bus.hold_cnt, c % 4);
            end
        end
    endtask

    task automatic test_fairness();
        int want_id;
        do_reset();
        bus.req = 8'hFF;
        for (int c = 0; c < 32; c++) begin
            tick();
            want_id = 7 - ((c / 4) % 8);
            checks++;
            if (bus.gnt_id !== 3'(want_id) || bus.hold_cnt !== 3'(c % 4) || !$onehot(bus.gnt)
                || bus.gnt[want_id] !== 1'b1) begin
                errors++;
                $display("FAIL fairness c=%0d: gnt=%h id=%0d cnt=%0d, want id %0d cnt %0d",
                         c, bus.gnt, bus.gnt_id, bus.hold_cnt, want_id, c % 4);
            end
        end
    endtask

    task automatic test_en_drop();
        do_reset();
        bus.req = 8'h04;
        tick();
        tick();
        bus.en = 1'b0;
        tick();
        checks++;
        if (bus.gnt !== 8'h00 || bus.gnt_v !== 1'b0 || bus.hold_cnt !== 3'd0 || bus.gnt_id !== 3'd2) begin
            errors++;
            $display("FAIL en_drop: gnt=%h v=%b cnt=%0d id=%0d, want 00/0/0/2",
                     bus.gnt, bus.gnt_v, bus.hold_cnt, bus.gnt_id);
        end
        tick();
        checks++;
        if (bus.gnt !== 8'h00 || bus.gnt_v !== 1'b0) begin
            errors++;
            $display("FAIL en_low_blocks: gnt=%h v=%b, want 00/0", bus.gnt, bus.gnt_v);
        end
        bus.en  = 1'b1;
        bus.req = 8'h06;
        tick();
        checks++;
        if (bus.gnt !== 8'h02 || bus.gnt_id !== 3'd1 || bus.gnt_v !== 1'b1 || bus.hold_cnt !== 3'd0) begin
            errors++;
            $display("FAIL en_regrant: gnt=%h id=%0d v=%b cnt=%0d, want 02/1/1/0",
                     bus.gnt, bus.gnt_id, bus.gnt_v, bus.hold_cnt);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        bus.req = 8'hFF;
        tick();
        tick();
        rst     = 1'b1;
        bus.req = 8'h11;
        tick();
        checks++;
        if (bus.gnt !== 8'h00 || bus.gnt_v !== 1'b0 || bus.gnt_id !== 3'd0 || bus.hold_cnt !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: gnt=%h v=%b id=%0d cnt=%0d, want all 0",
                     bus.gnt, bus.gnt_v, bus.gnt_id, bus.hold_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.gnt !== 8'h10 || bus.gnt_id !== 3'd4) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%h id=%0d, want 10/4", bus.gnt, bus.gnt_id);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 3))
                0:       bus.req = 8'($urandom);
                1:       bus.req = 8'($urandom) & 8'($urandom);
                2:       bus.req = 8'h00;
                default: ;
            endcase
            bus.en = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 79) == 0);
            tick();
            checks++;
            if (bus.gnt !== exp_gnt() || bus.gnt_id !== 3'(m_gid) || bus.hold_cnt !== 3'(m_cnt)
                || bus.gnt_v !== (m_owner >= 0)) begin
                errors++;
                $display("FAIL random c=%0d: gnt=%h id=%0d cnt=%0d v=%b, want %h/%0d/%0d/%b",
                         c, bus.gnt, bus.gnt_id, bus.hold_cnt, bus.gnt_v,
                         exp_gnt(), m_gid, m_cnt, (m_owner >= 0));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.en  = 1'b1;
        bus.req = 8'h00;
        test_reset();
        test_timeout_rotate();
        test_owner_drop();
        test_single_timeout();
        test_fairness();
        test_en_drop();
        test_reset_mid_grant();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
